// File: rtl/lms_fifo_frame_ctrl.sv
// lms_fifo_frame_ctrl
//
// Frame scheduler in front of the LMS audio sample FIFO (lms_fifos, 1-cycle read latency).
// The write side registers incoming samples into the FIFO and discards them once the FIFO
// reports almost_full or full. The read side waits for a full frame of FRAME_LEN samples in
// the FIFO and bursts exactly that many samples to the LMS core. The burst goes through a
// 2-entry skid buffer, so m_ready can stall the core interface for any length of time.
//
// Optional feature: define LMS_FIFO_FRAME_CTRL_OVF_CNT_EN to enable the saturating
// overflow_cnt drop counter. When it is undefined, overflow_cnt is tied to zero.
//
// Ports:
//   clk, tb_rst          clock; asynchronous active-high reset (also resets the FIFO)
//   s_valid, s_data      audio sample input
//   s_drop               one-cycle pulse when a sample was discarded
//   fifo_wr_en/_data     FIFO write port
//   fifo_almost_full     FIFO almost_full flag
//   fifo_wr_full         FIFO full flag
//   fifo_rd_en           FIFO read strobe
//   fifo_rd_data         FIFO read data, valid the cycle after fifo_rd_en
//   fifo_rd_empty        FIFO empty flag
//   fifo_rd_water_level  FIFO read-side fill level
//   m_valid/m_data/m_last/m_ready  frame stream to the LMS core
//   busy                 read FSM not idle
//   frame_cnt            completed frames (wrapping)
//   overflow_cnt         dropped samples (saturating, optional)
module lms_fifo_frame_ctrl #(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned DEPTH_WIDTH = 10,
  parameter int unsigned FRAME_LEN   = 256
) (
  input  logic                  clk,
  input  logic                  tb_rst,
  input  logic                  s_valid,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  s_drop,
  output logic                  fifo_wr_en,
  output logic [DATA_WIDTH-1:0] fifo_wr_data,
  input  logic                  fifo_almost_full,
  input  logic                  fifo_wr_full,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  input  logic                  fifo_rd_empty,
  input  logic [DEPTH_WIDTH:0]  fifo_rd_water_level,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  input  logic                  m_ready,
  output logic                  busy,
  output logic [15:0]           frame_cnt,
  output logic [15:0]           overflow_cnt
);

  localparam int unsigned CntW = DEPTH_WIDTH + 1;
  localparam logic [CntW-1:0] FrameLen = CntW'(FRAME_LEN);

  typedef enum logic [1:0] {StIdle, StStream, StDrain, StGap} state_e;

  // ---------------------------------------------------------------------------------------------
  // Write side
  // ---------------------------------------------------------------------------------------------
  logic                  wr_accept;
  logic                  wr_drop;
  logic                  wr_en_q;
  logic                  drop_q;
  logic [DATA_WIDTH-1:0] wr_data_q;

  assign wr_accept = s_valid & ~fifo_almost_full & ~fifo_wr_full;
  assign wr_drop   = s_valid & ~wr_accept;

  always_ff @(posedge clk or posedge tb_rst) begin
    if (tb_rst) begin
      wr_en_q   <= 1'b0;
      drop_q    <= 1'b0;
      wr_data_q <= '0;
    end else begin
      wr_en_q <= wr_accept;
      drop_q  <= wr_drop;
      if (wr_accept) begin
        wr_data_q <= s_data;
      end
    end
  end

  assign fifo_wr_en   = wr_en_q;
  assign fifo_wr_data = wr_data_q;
  assign s_drop       = drop_q;

`ifdef LMS_FIFO_FRAME_CTRL_OVF_CNT_EN
  logic [15:0] ovf_cnt_q;

  // Counts on the same edge that raises s_drop, so both become visible together.
  always_ff @(posedge clk or posedge tb_rst) begin
    if (tb_rst) begin
      ovf_cnt_q <= '0;
    end else if (wr_drop && (ovf_cnt_q != 16'hFFFF)) begin
      ovf_cnt_q <= ovf_cnt_q + 16'd1;
    end
  end

  assign overflow_cnt = ovf_cnt_q;
`else
  assign overflow_cnt = '0;
`endif

  // ---------------------------------------------------------------------------------------------
  // Read FSM and skid buffer
  // ---------------------------------------------------------------------------------------------
  state_e                state_q, state_d;
  logic [CntW-1:0]       rd_remain_q, rd_remain_d;
  logic [CntW-1:0]       out_remain_q, out_remain_d;
  logic [1:0]            occ_q, occ_d;
  logic                  infl_q;
  logic                  wr_ptr_q, rd_ptr_q;
  logic [DATA_WIDTH-1:0] skid_q [2];
  logic [15:0]           frame_cnt_q;
  logic                  frame_done;
  logic                  pop;
  logic                  rd_en;
  logic [2:0]            level;

  assign m_valid = (occ_q != 2'd0);
  assign m_data  = skid_q[rd_ptr_q];
  assign m_last  = (out_remain_q == CntW'(1)) & m_valid;
  assign pop     = m_valid & m_ready;

  // Entries that will occupy the buffer next cycle if no new read is issued; a new read is
  // only issued when it is guaranteed a free slot on arrival.
  assign level = {1'b0, occ_q} + {2'b00, infl_q} - {2'b00, pop};
  assign rd_en = (state_q == StStream) & (rd_remain_q != '0) & ~fifo_rd_empty & (level < 3'd2);

  assign occ_d = occ_q + {1'b0, infl_q} - {1'b0, pop};

  always_comb begin
    state_d      = state_q;
    rd_remain_d  = rd_remain_q;
    out_remain_d = out_remain_q;
    frame_done   = 1'b0;

    if (pop) begin
      out_remain_d = out_remain_q - CntW'(1);
    end

    unique case (state_q)
      StIdle: begin
        if (fifo_rd_water_level >= FrameLen) begin
          state_d      = StStream;
          rd_remain_d  = FrameLen;
          out_remain_d = FrameLen;
        end
      end
      StStream: begin
        if (rd_en) begin
          rd_remain_d = rd_remain_q - CntW'(1);
        end
        if (rd_remain_d == '0) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (pop && m_last) begin
          frame_done = 1'b1;
          state_d    = StGap;
        end
      end
      // One dead cycle so the FIFO water level reflects the frame just read.
      StGap: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge tb_rst) begin
    if (tb_rst) begin
      state_q      <= StIdle;
      rd_remain_q  <= '0;
      out_remain_q <= '0;
      occ_q        <= 2'd0;
      infl_q       <= 1'b0;
      wr_ptr_q     <= 1'b0;
      rd_ptr_q     <= 1'b0;
      skid_q[0]    <= '0;
      skid_q[1]    <= '0;
      frame_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      rd_remain_q  <= rd_remain_d;
      out_remain_q <= out_remain_d;
      occ_q        <= occ_d;
      infl_q       <= rd_en;
      // FIFO data for last cycle's read is on fifo_rd_data now.
      if (infl_q) begin
        skid_q[wr_ptr_q] <= fifo_rd_data;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      if (frame_done) begin
        frame_cnt_q <= frame_cnt_q + 16'd1;
      end
    end
  end

  assign fifo_rd_en = rd_en;
  assign busy       = (state_q != StIdle);
  assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_lms_fifo_frame_ctrl.sv
// Testbench for lms_fifo_frame_ctrl. Three DUT instances share one clock and reset, and each
// one drives its own behavioural FIFO model: FRAME_LEN 256 (main), 1024 (overflow), 1 (single).
// Samples that are expected to reach the LMS side go into a per-instance scoreboard queue when
// they are driven. A monitor pops the queue on every accepted output sample and checks data,
// m_last position, buffer occupancy and frame-gap timing.
module tb_lms_fifo_frame_ctrl;

  localparam int NI = 3;
  localparam int DW = 16;
  localparam int AW = 10;

  logic clk = 1'b0;
  logic tb_rst;
  always #5 clk = ~clk;

  logic [NI-1:0]         s_valid, s_drop, wr_en, af, wfull, rd_en, rempty;
  logic [NI-1:0]         m_valid, m_last, m_ready, busy;
  logic [NI-1:0][DW-1:0] s_data, wr_data, rd_data, m_data;
  logic [NI-1:0][AW:0]   wl;
  logic [NI-1:0][15:0]   frame_cnt, ovf_cnt;

  for (genvar g = 0; g < NI; g++) begin : g_inst
    int            cnt, wp, rp;
    logic [DW-1:0] mem [1024];
    logic [DW-1:0] rdq;
    logic          do_wr, do_rd;

    assign do_wr = wr_en[g] && (cnt < 1024);
    assign do_rd = rd_en[g] && (cnt > 0);

    always @(posedge clk or posedge tb_rst) begin
      if (tb_rst) begin
        cnt <= 0;
        wp  <= 0;
        rp  <= 0;
        rdq <= '0;
      end else begin
        if (do_wr) begin
          mem[wp] <= wr_data[g];
          wp      <= (wp + 1) % 1024;
        end
        if (do_rd) begin
          rdq <= mem[rp];
          rp  <= (rp + 1) % 1024;
        end
        cnt <= cnt + (do_wr ? 1 : 0) - (do_rd ? 1 : 0);
      end
    end

    assign af[g]      = (cnt >= 1020);
    assign wfull[g]   = (cnt >= 1024);
    assign rempty[g]  = (cnt == 0);
    assign wl[g]      = 11'(cnt);
    assign rd_data[g] = rdq;

    lms_fifo_frame_ctrl #(
      .DATA_WIDTH (DW),
      .DEPTH_WIDTH(AW),
      .FRAME_LEN  ((g == 0) ? 256 : ((g == 1) ? 1024 : 1))
    ) u_dut (
      .clk                (clk),
      .tb_rst             (tb_rst),
      .s_valid            (s_valid[g]),
      .s_data             (s_data[g]),
      .s_drop             (s_drop[g]),
      .fifo_wr_en         (wr_en[g]),
      .fifo_wr_data       (wr_data[g]),
      .fifo_almost_full   (af[g]),
      .fifo_wr_full       (wfull[g]),
      .fifo_rd_en         (rd_en[g]),
      .fifo_rd_data       (rd_data[g]),
      .fifo_rd_empty      (rempty[g]),
      .fifo_rd_water_level(wl[g]),
      .m_valid            (m_valid[g]),
      .m_data             (m_data[g]),
      .m_last             (m_last[g]),
      .m_ready            (m_ready[g]),
      .busy               (busy[g]),
      .frame_cnt          (frame_cnt[g]),
      .overflow_cnt       (ovf_cnt[g])
    );
  end

  // Bench state
  int            n_vec = 0;
  int            n_err = 0;
  int            cyc = 0;
  logic [DW-1:0] sbq [NI][$];
  int            pop_cnt [NI];
  int            b_occ [NI];
  bit            infl [NI];
  int            rd_cnt [NI];
  int            wr_cnt [NI];
  int            drop_cnt [NI];
  int            lp_cyc [NI];
  bit            wait_rd [NI];
  int            gap [NI];
  int            busy_p1 [NI];
  int            busy_p3 [NI];
  logic [3:0]    rpat [NI];

  function automatic int fl(input int g);
    case (g)
      0:       return 256;
      1:       return 1024;
      default: return 1;
    endcase
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  task automatic mon_clear(input int g);
    sbq[g].delete();
    pop_cnt[g] = 0;
    b_occ[g]   = 0;
    infl[g]    = 1'b0;
    wait_rd[g] = 1'b0;
  endtask

  // One clock cycle: monitor at the falling edge, then return 1 time unit after the rising edge.
  task automatic tick();
    logic          pop;
    logic [DW-1:0] exp_d;
    bit            is_last;
    @(negedge clk);
    for (int g = 0; g < NI; g++) begin
      if (!tb_rst) begin
        check("occ_bound", int'((b_occ[g] + int'(infl[g])) <= 2), 1);
        check("m_valid_occ", int'(m_valid[g]), int'(b_occ[g] != 0));
        check("m_last_gated", int'(m_last[g] & ~m_valid[g]), 0);
        pop = m_valid[g] & m_ready[g];
        if (pop) begin
          check("sb_underflow", int'(sbq[g].size() > 0), 1);
          if (sbq[g].size() > 0) begin
            exp_d   = sbq[g].pop_front();
            is_last = (pop_cnt[g] + 1 == fl(g));
            check("m_data", int'(m_data[g]), int'(exp_d));
            check("m_last", int'(m_last[g]), int'(is_last));
            if (is_last) begin
              pop_cnt[g] = 0;
              lp_cyc[g]  = cyc;
              wait_rd[g] = 1'b1;
            end else begin
              pop_cnt[g]++;
            end
          end
        end
        if (cyc == lp_cyc[g] + 1) busy_p1[g] = int'(busy[g]);
        if (cyc == lp_cyc[g] + 3) busy_p3[g] = int'(busy[g]);
        if (rd_en[g]) begin
          rd_cnt[g]++;
          if (wait_rd[g]) begin
            gap[g]     = cyc - lp_cyc[g];
            wait_rd[g] = 1'b0;
          end
        end
        if (wr_en[g]) wr_cnt[g]++;
        if (s_drop[g]) drop_cnt[g]++;
        b_occ[g] = b_occ[g] + int'(infl[g]) - int'(pop);
        infl[g]  = rd_en[g];
      end
    end
    cyc++;
    @(posedge clk);
    #1;
    for (int g = 0; g < NI; g++) m_ready[g] = rpat[g][cyc % 4];
  endtask

  task automatic write_samples(input int g, input int n, input int base, input bit chk);
    for (int i = 0; i < n; i++) begin
      s_valid[g] = 1'b1;
      s_data[g]  = 16'(base + i);
      if (chk) sbq[g].push_back(16'(base + i));
      tick();
      if (chk) begin
        check("wr_en_lat", int'(wr_en[g]), 1);
        check("wr_data", int'(wr_data[g]), (base + i) & 16'hFFFF);
        check("no_drop", int'(s_drop[g]), 0);
      end
    end
    s_valid[g] = 1'b0;
    tick();
    if (chk) check("wr_en_idle", int'(wr_en[g]), 0);
  endtask

  task automatic check_reset_outputs();
    for (int g = 0; g < NI; g++) begin
      check("rst_outputs", int'(|{s_drop[g], wr_en[g], wr_data[g], rd_en[g], m_valid[g],
                                  m_data[g], m_last[g], busy[g], frame_cnt[g], ovf_cnt[g]}), 0);
    end
  endtask

  typedef struct {
    int         n_wr;
    logic [3:0] pre;
    logic [3:0] run;
    int         frames;
    int         rds;
    int         pend;
    int         gap;
    bit         chk_busy;
  } vec_t;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [5];
    int   base;
    int   t;
    int   rd_base;
    int   exp_ovf;

    tbl[0] = '{256, 4'b1111, 4'b1111, 1, 256,  0,   -1, 1'b1};
    tbl[1] = '{255, 4'b1111, 4'b1111, 1, 256,  255, -1, 1'b0};
    tbl[2] = '{1,   4'b1111, 4'b1111, 2, 512,  0,   -1, 1'b1};
    tbl[3] = '{256, 4'b1001, 4'b1001, 3, 768,  0,   -1, 1'b1};
    tbl[4] = '{512, 4'b0000, 4'b1111, 5, 1280, 0,   3,  1'b1};

    tb_rst  = 1'b1;
    s_valid = '0;
    s_data  = '0;
    m_ready = '0;
    for (int g = 0; g < NI; g++) begin
      rpat[g]     = 4'b0000;
      rd_cnt[g]   = 0;
      wr_cnt[g]   = 0;
      drop_cnt[g] = 0;
      lp_cyc[g]   = -100;
      gap[g]      = -1;
      busy_p1[g]  = -1;
      busy_p3[g]  = -1;
      mon_clear(g);
    end
    repeat (3) tick();
    check_reset_outputs();
    tb_rst = 1'b0;
    repeat (2) tick();

    // Frame table on the FRAME_LEN=256 instance.
    base = 0;
    for (int r = 0; r < 5; r++) begin
      gap[0]     = -1;
      wait_rd[0] = 1'b0;
      busy_p1[0] = -1;
      busy_p3[0] = -1;
      rpat[0]    = tbl[r].pre;
      write_samples(0, tbl[r].n_wr, base, 1'b1);
      base += tbl[r].n_wr;
      rpat[0] = tbl[r].run;
      t = 0;
      while (!((int'(frame_cnt[0]) == tbl[r].frames) && !busy[0]) && (t < 4000)) begin
        tick();
        t++;
      end
      check("frame_done", int'(t < 4000), 1);
      repeat (8) tick();
      check("frame_cnt", int'(frame_cnt[0]), tbl[r].frames);
      check("rd_cnt", rd_cnt[0], tbl[r].rds);
      check("busy_idle", int'(busy[0]), 0);
      check("sb_pending", sbq[0].size(), tbl[r].pend);
      check("frame_gap", gap[0], tbl[r].gap);
      if (tbl[r].chk_busy) begin
        check("busy_gap", busy_p1[0], 1);
        check("busy_low", busy_p3[0], 0);
      end
    end

    // Overflow on the FRAME_LEN=1024 instance: the frame never starts. With one write always
    // in flight, samples 0..1020 are accepted and every later one is dropped.
    rpat[1] = 4'b0000;
    write_samples(1, 1030, 16'h2000, 1'b0);
    repeat (3) tick();
    check("ovf_writes", wr_cnt[1], 1021);
    check("ovf_fifo_cnt", g_inst[1].cnt, 1021);
    check("ovf_drops", drop_cnt[1], 9);
    check("ovf_no_read", rd_cnt[1], 0);
`ifdef LMS_FIFO_FRAME_CTRL_OVF_CNT_EN
    exp_ovf = 9;
`else
    exp_ovf = 0;
`endif
    check("overflow_cnt", int'(ovf_cnt[1]), exp_ovf);
    s_valid[1] = 1'b1;
    s_data[1]  = 16'hDEAD;
    tick();
    s_valid[1] = 1'b0;
    check("drop_pulse", int'(s_drop[1]), 1);
    check("drop_no_wr", int'(wr_en[1]), 0);
`ifdef LMS_FIFO_FRAME_CTRL_OVF_CNT_EN
    exp_ovf = 10;
`else
    exp_ovf = 0;
`endif
    check("overflow_inc", int'(ovf_cnt[1]), exp_ovf);
    tick();
    check("drop_end", int'(s_drop[1]), 0);

    // FRAME_LEN=1: every sample is its own frame with m_last set.
    rpat[2] = 4'b1111;
    write_samples(2, 4, 16'h3000, 1'b1);
    t = 0;
    while (!((frame_cnt[2] == 16'd4) && !busy[2]) && (t < 200)) begin
      tick();
      t++;
    end
    check("fl1_done", int'(t < 200), 1);
    check("fl1_frames", int'(frame_cnt[2]), 4);
    check("fl1_pending", sbq[2].size(), 0);

    // Reset in the middle of a streaming frame.
    rpat[0] = 4'b1111;
    write_samples(0, 256, 16'h0800, 1'b1);
    t = 0;
    while ((pop_cnt[0] < 100) && (t < 2000)) begin
      tick();
      t++;
    end
    check("mid_frame_reached", int'(t < 2000), 1);
    check("mid_frame_busy", int'(busy[0]), 1);
    tb_rst = 1'b1;
    #1;
    check_reset_outputs();
    repeat (2) tick();
    check_reset_outputs();
    for (int g = 0; g < NI; g++) mon_clear(g);
    tb_rst = 1'b0;
    tick();
    rd_base = rd_cnt[0];
    write_samples(0, 255, 16'h1000, 1'b1);
    repeat (8) tick();
    check("rst_no_read", rd_cnt[0] - rd_base, 0);
    check("rst_no_busy", int'(busy[0]), 0);
    check("rst_frame_cnt", int'(frame_cnt[0]), 0);
    check("rst_pending", sbq[0].size(), 255);
    write_samples(0, 1, 16'h10FF, 1'b1);
    t = 0;
    while (!((frame_cnt[0] == 16'd1) && !busy[0]) && (t < 1000)) begin
      tick();
      t++;
    end
    check("rst_frame_done", int'(t < 1000), 1);
    check("rst_frame_cnt1", int'(frame_cnt[0]), 1);
    check("rst_drained", sbq[0].size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
